alarm_tone_gen: RTL and testbench

- Upstream audio-source stage for the alarm's I2S output path.
- Produces signed 16-bit PCM samples of a beep pattern: tone bursts separated by gaps, with a longer pause between bursts.
- Hands one sample per I2S frame to the I2S transmitter through a request/valid handshake. This replaces the fixed 0/1 stand-in sample currently fed to that transmitter.
- Runs entirely in the system clock domain. The transmitter issues a one-cycle request per left/right frame.

---
 rtl/alarm_audio_pkg.sv | 27 ++
 rtl/tone_square_osc.sv | 50 +++++
 rtl/alarm_tone_gen.sv | 145 ++++++++++++++
 tb/tb_alarm_tone_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_audio_pkg.sv
// Shared types and sizing helpers for the alarm audio source.
package alarm_audio_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEEP  = 2'd1,
        GAP   = 2'd2,
        PAUSE = 2'd3
    } tone_state_e;

    localparam sample_t SILENCE = '0;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tone_square_osc.sv
// Square-wave oscillator: half-cycle counter plus polarity, stepped once per emitted sample.
module tone_square_osc
    import alarm_audio_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 24,
    parameter sample_t     AMPLITUDE   = 16'h2000
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    advance,
    input  logic    restart,
    output sample_t tone_c
);

    localparam int unsigned HP_W = clog2(HALF_PERIOD) + 1;
    localparam sample_t     NEG_AMPLITUDE = -AMPLITUDE;

    logic [HP_W-1:0] half_cnt_q, half_cnt_d;
    logic            neg_q, neg_d;

    // Restart wins so every beep begins on the positive half-cycle.
    always_comb begin
        half_cnt_d = half_cnt_q;
        neg_d      = neg_q;
        if (restart) begin
            half_cnt_d = '0;
            neg_d      = 1'b0;
        end else if (advance) begin
            if (half_cnt_q == HP_W'(HALF_PERIOD - 1)) begin
                half_cnt_d = '0;
                neg_d      = ~neg_q;
            end else begin
                half_cnt_d = half_cnt_q + HP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half_cnt_q <= '0;
            neg_q      <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            neg_q      <= neg_d;
        end
    end

    assign tone_c = neg_q ? NEG_AMPLITUDE : AMPLITUDE;

endmodule

// File: rtl/alarm_tone_gen.sv
// Alarm beep-pattern PCM source feeding the I2S transmitter one sample per request.
module alarm_tone_gen
    import alarm_audio_pkg::*;
#(
    parameter sample_t     AMPLITUDE       = 16'h2000,
    parameter int unsigned HALF_PERIOD     = 24,
    parameter int unsigned BEEP_LEN        = 4800,
    parameter int unsigned GAP_LEN         = 4800,
    parameter int unsigned BEEPS_PER_BURST = 4,
    parameter int unsigned PAUSE_LEN       = 24000
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    alarm_trigger,
    input  logic    alarm_stop,
    input  logic    sample_req,
    output sample_t sample_out,
    output logic    sample_valid,
    output logic    tone_active
);

    localparam int unsigned MAX_BG  = (BEEP_LEN > GAP_LEN) ? BEEP_LEN : GAP_LEN;
    localparam int unsigned MAX_LEN = (MAX_BG > PAUSE_LEN) ? MAX_BG : PAUSE_LEN;
    localparam int unsigned CNT_W   = clog2(MAX_LEN) + 1;
    localparam int unsigned BC_W    = clog2(BEEPS_PER_BURST) + 1;

    tone_state_e      state_q, state_d;
    logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
    logic [BC_W-1:0]  beep_cnt_q, beep_cnt_d;
    sample_t          sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             tone_q, tone_d;

    logic [CNT_W-1:0] seg_last;
    logic             seg_end;
    logic             osc_advance;
    logic             osc_restart;
    sample_t          osc_c;

    tone_square_osc #(
        .HALF_PERIOD (HALF_PERIOD),
        .AMPLITUDE   (AMPLITUDE)
    ) u_osc (
        .clk     (clk),
        .rst     (rst),
        .advance (osc_advance),
        .restart (osc_restart),
        .tone_c  (osc_c)
    );

    assign osc_advance = sample_req && (state_q == BEEP) && !alarm_stop;
    assign osc_restart = (state_d != BEEP) || (state_q != BEEP);

    // Next state, segment/beep counters and the emitted sample.
    always_comb begin
        state_d    = state_q;
        seg_cnt_d  = seg_cnt_q;
        beep_cnt_d = beep_cnt_q;
        sample_d   = sample_q;
        valid_d    = sample_req;
        seg_last   = (state_q == GAP)   ? CNT_W'(GAP_LEN - 1)   :
                     (state_q == PAUSE) ? CNT_W'(PAUSE_LEN - 1) :
                                          CNT_W'(BEEP_LEN - 1);
        seg_end    = (seg_cnt_q == seg_last);

        if (sample_req) begin
            sample_d = ((state_q == BEEP) && !alarm_stop) ? osc_c : SILENCE;
        end

        if (alarm_stop) begin
            state_d    = IDLE;
            seg_cnt_d  = '0;
            beep_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (alarm_trigger) begin
                        state_d    = BEEP;
                        seg_cnt_d  = '0;
                        beep_cnt_d = '0;
                    end
                end
                // A beep always runs to its end so release never clicks mid-tone.
                BEEP: begin
                    if (sample_req) begin
                        if (!seg_end) begin
                            seg_cnt_d = seg_cnt_q + CNT_W'(1);
                        end else begin
                            seg_cnt_d = '0;
                            if (!alarm_trigger) begin
                                state_d    = IDLE;
                                beep_cnt_d = '0;
                            end else if (beep_cnt_q < BC_W'(BEEPS_PER_BURST - 1)) begin
                                state_d    = GAP;
                                beep_cnt_d = beep_cnt_q + BC_W'(1);
                            end else begin
                                state_d    = PAUSE;
                                beep_cnt_d = '0;
                            end
                        end
                    end
                end
                default: begin
                    if (!alarm_trigger) begin
                        state_d    = IDLE;
                        seg_cnt_d  = '0;
                        beep_cnt_d = '0;
                    end else if (sample_req) begin
                        if (!seg_end) begin
                            seg_cnt_d = seg_cnt_q + CNT_W'(1);
                        end else begin
                            state_d   = BEEP;
                            seg_cnt_d = '0;
                        end
                    end
                end
            endcase
        end

        tone_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            seg_cnt_q  <= '0;
            beep_cnt_q <= '0;
            sample_q   <= SILENCE;
            valid_q    <= 1'b0;
            tone_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_cnt_q  <= seg_cnt_d;
            beep_cnt_q <= beep_cnt_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            tone_q     <= tone_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign tone_active  = tone_q;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Bench for alarm_tone_gen: position-in-burst reference model, directed and random scenarios.
module tb_alarm_tone_gen;

    localparam int HP = 2;
    localparam int BL = 8;
    localparam int GL = 4;
    localparam int NB = 2;
    localparam int PL = 6;
    localparam logic [15:0] AMP = 16'h2000;
    localparam logic [15:0] NEG = 16'hE000;
    localparam int C         = BL + GL;
    localparam int BEEPS_END = (NB - 1) * C + BL;
    localparam int L         = BEEPS_END + PL;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        trig = 1'b0;
    logic        stop = 1'b0;
    logic        req  = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        tone_active;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: alarm active flag and position within one burst pattern.
    bit          m_active   = 1'b0;
    int          m_pos      = 0;
    logic [15:0] exp_sample = 16'h0;
    logic        exp_valid  = 1'b0;

    always #5 clk = ~clk;

    alarm_tone_gen #(
        .AMPLITUDE       (16'h2000),
        .HALF_PERIOD     (HP),
        .BEEP_LEN        (BL),
        .GAP_LEN         (GL),
        .BEEPS_PER_BURST (NB),
        .PAUSE_LEN       (PL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alarm_trigger (trig),
        .alarm_stop    (stop),
        .sample_req    (req),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .tone_active   (tone_active)
    );

    function automatic bit in_beep(input int p);
        return (p < BEEPS_END) && ((p % C) < BL);
    endfunction

    function automatic bit beep_last(input int p);
        return in_beep(p) && ((p % C) == BL - 1);
    endfunction

    function automatic logic [15:0] beep_val(input int p);
        return ((((p % C) / HP) % 2) == 0) ? AMP : NEG;
    endfunction

    task automatic model_edge();
        if (!rst) begin
            m_active   = 1'b0;
            m_pos      = 0;
            exp_sample = 16'h0;
            exp_valid  = 1'b0;
            return;
        end
        exp_valid = req;
        if (req) exp_sample = (m_active && !stop && in_beep(m_pos)) ? beep_val(m_pos) : 16'h0;
        if (stop) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (trig) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else if (!trig && !in_beep(m_pos)) begin
            m_active = 1'b0;
        end else if (req) begin
            if (!trig && beep_last(m_pos)) m_active = 1'b0;
            else m_pos = (m_pos + 1) % L;
        end
    endtask

    task automatic tick(input bit t, input bit s, input bit r);
        trig = t;
        stop = s;
        req  = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({sample_out, sample_valid, tone_active} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h/%b/%b want 0/0/0", sample_out, sample_valid, tone_active);
        end
        #4 rst = 1'b1;
        tick(1, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0, 1);
        #2 rst = 1'b0;
        #1;
        m_active = 1'b0; m_pos = 0; exp_sample = 16'h0; exp_valid = 1'b0;
        n_tests++;
        if ({sample_out, sample_valid, tone_active} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h/%b/%b want 0/0/0", sample_out, sample_valid, tone_active);
        end
        #1 rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, (i % 2) == 0);
            n_tests++;
            if (sample_out !== exp_sample || sample_valid !== exp_valid || tone_active !== m_active) begin
                n_fail++;
                $display("FAIL reset_idle_req i=%0d: got %h/%b/%b want %h/%b/%b", i,
                         sample_out, sample_valid, tone_active, exp_sample, exp_valid, m_active);
            end
        end
    endtask

    task automatic test_pattern();
        logic [15:0] got [40];
        tick(0, 1, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 40; i++) begin
            tick(1, 0, 1);
            got[i] = sample_out;
            n_tests++;
            if (sample_out !== exp_sample || sample_valid !== exp_valid || tone_active !== 1'b1) begin
                n_fail++;
                $display("FAIL pattern i=%0d: got %h/%b/%b want %h/%b/1", i,
                         sample_out, sample_valid, tone_active, exp_sample, exp_valid);
            end
        end
        n_tests++;
        if (got[0] !== 16'h2000 || got[2] !== 16'hE000 || got[8] !== 16'h0 || got[19] !== 16'hE000
            || got[20] !== 16'h0 || got[25] !== 16'h0 || got[26] !== 16'h2000) begin
            n_fail++;
            $display("FAIL pattern_literal: got %h %h %h %h %h %h %h want 2000 e000 0000 e000 0000 0000 2000",
                     got[0], got[2], got[8], got[19], got[20], got[25], got[26]);
        end
    endtask

    task automatic test_trigger_drop();
        tick(0, 1, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 11; i++) begin
            tick(i < 3, 0, 1);
            n_tests++;
            if (sample_out !== exp_sample || sample_valid !== exp_valid || tone_active !== m_active) begin
                n_fail++;
                $display("FAIL trigger_drop i=%0d: got %h/%b/%b want %h/%b/%b", i,
                         sample_out, sample_valid, tone_active, exp_sample, exp_valid, m_active);
            end
            if (i == 6 || i == 7) begin
                n_tests++;
                if (tone_active !== (i == 6) || sample_out !== NEG) begin
                    n_fail++;
                    $display("FAIL trigger_drop_end i=%0d: got %h/%b want %h/%b", i,
                             sample_out, tone_active, NEG, (i == 6));
                end
            end
        end
    endtask

    task automatic test_stop();
        tick(0, 1, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 15; i++) tick(1, 0, 1);
        tick(1, 1, 1);
        n_tests++;
        if (sample_out !== 16'h0 || sample_valid !== 1'b1 || tone_active !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_same_cycle: got %h/%b/%b want 0000/1/0", sample_out, sample_valid, tone_active);
        end
        tick(1, 0, 0);
        for (int i = 0; i < 14; i++) begin
            tick(1, 0, 1);
            n_tests++;
            if (sample_out !== exp_sample || sample_valid !== exp_valid || tone_active !== m_active) begin
                n_fail++;
                $display("FAIL stop_retrigger i=%0d: got %h/%b/%b want %h/%b/%b", i,
                         sample_out, sample_valid, tone_active, exp_sample, exp_valid, m_active);
            end
            if (i == 0 || i == 12) begin
                n_tests++;
                if (sample_out !== 16'h2000) begin
                    n_fail++;
                    $display("FAIL stop_restart_sample i=%0d: got %h want 2000", i, sample_out);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_valid = 0;
        tick(0, 1, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tick(1, 0, 1);
            if (sample_valid === 1'b1) n_valid++;
            n_tests++;
            if (sample_out !== exp_sample || sample_valid !== exp_valid || tone_active !== m_active) begin
                n_fail++;
                $display("FAIL back_to_back i=%0d: got %h/%b/%b want %h/%b/%b", i,
                         sample_out, sample_valid, tone_active, exp_sample, exp_valid, m_active);
            end
        end
        tick(1, 0, 0);
        if (sample_valid === 1'b1) n_valid++;
        n_tests++;
        if (n_valid != 16) begin
            n_fail++;
            $display("FAIL back_to_back_count: got %0d valid pulses want 16", n_valid);
        end
    endtask

    task automatic test_simultaneous();
        tick(0, 1, 0);
        tick(0, 0, 0);
        tick(1, 1, 1);
        tick(1, 1, 1);
        n_tests++;
        if (sample_out !== 16'h0 || sample_valid !== 1'b1 || tone_active !== 1'b0) begin
            n_fail++;
            $display("FAIL simultaneous: got %h/%b/%b want 0000/1/0", sample_out, sample_valid, tone_active);
        end
    endtask

    task automatic test_random();
        bit t = 1'b1;
        tick(0, 1, 0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 29) == 0) t = ~t;
            tick(t, $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1);
            n_tests++;
            if (sample_out !== exp_sample || sample_valid !== exp_valid || tone_active !== m_active) begin
                n_fail++;
                $display("FAIL random i=%0d: got %h/%b/%b want %h/%b/%b", i,
                         sample_out, sample_valid, tone_active, exp_sample, exp_valid, m_active);
            end
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_pattern();
        test_trigger_drop();
        test_stop();
        test_back_to_back();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
